// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage feeding the opcode decoder.
// One outstanding memory request; fetched word is held until the decoder accepts it.
module fetch_pc_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] link_addr,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic              jal,
  input  logic              jr,
  input  logic [IMM_W-1:0]  br_offset,
  input  logic [ADDR_W-1:0] j_target,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic              redirect,
  output logic [15:0]       inst_count
);

  typedef enum logic [1:0] {
    RESET_WAIT,
    FETCH,
    HOLD
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              redir_q, redir_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] npc;
  logic              taken;
  logic              hs;

  // Offset is sign-extended or truncated to the PC width; wrap is implicit.
  assign off_ext = ADDR_W'($signed(br_offset));
  assign seq_pc  = pc_q + ADDR_W'(1);
  assign br_pc   = seq_pc + off_ext;
  assign hs      = valid_q & inst_ready;

  always_comb begin
    npc   = seq_pc;
    taken = 1'b1;
    if (jr) begin
      npc = jr_addr;
    end else if (jump || jal) begin
      npc = j_target;
    end else if (branch && zero) begin
      npc = br_pc;
    end else begin
      taken = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    redir_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      RESET_WAIT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          pc_d    = fpc_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hs) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 16'd1;
          redir_d = taken;
          fpc_d   = npc;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = RESET_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_WAIT;
      fpc_q   <= RESET_PC;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      valid_q <= 1'b0;
      redir_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      redir_q <= redir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = fpc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc_out     = pc_q;
  assign link_addr  = seq_pc;
  assign redirect   = redir_q;
  assign inst_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: random memory latency, backpressure
// and redirect controls checked against a next-PC reference model.
module tb_fetch_pc_unit;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int M  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic [DW-1:0] inst;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] link_addr;
  logic          branch = 1'b0;
  logic          zero = 1'b0;
  logic          jump = 1'b0;
  logic          jal = 1'b0;
  logic          jr = 1'b0;
  logic [IW-1:0] br_offset = '0;
  logic [AW-1:0] j_target = '0;
  logic [AW-1:0] jr_addr = '0;
  logic          redirect;
  logic [15:0]   inst_count;

  fetch_pc_unit #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .IMM_W(IW),
    .RESET_PC('0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .inst(inst),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .pc_out(pc_out),
    .link_addr(link_addr),
    .branch(branch),
    .zero(zero),
    .jump(jump),
    .jal(jal),
    .jr(jr),
    .br_offset(br_offset),
    .j_target(j_target),
    .jr_addr(jr_addr),
    .redirect(redirect),
    .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem [M];

  logic [AW-1:0] addr_q [$];
  logic [AW-1:0] ipc_q [$];
  logic          red_q [$];
  logic [15:0]   cnt_q [$];

  logic [AW-1:0] exp_pc;
  logic [15:0]   exp_cnt;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void flag(string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  function automatic logic [AW-1:0] next_pc(
    logic [AW-1:0] p, bit r, bit j, bit l, bit b, bit z,
    logic [IW-1:0] o, logic [AW-1:0] t, logic [AW-1:0] a);
    int v;
    if (r) return a;
    if (j || l) return t;
    if (b && z) v = int'(p) + 1 + int'($signed(o));
    else v = int'(p) + 1;
    v = v % M;
    if (v < 0) v += M;
    return v[AW-1:0];
  endfunction

  // Expected fetch address and expected held instruction are queued together.
  task automatic issue(logic [AW-1:0] a);
    addr_q.push_back(a);
    ipc_q.push_back(a);
  endtask

  task automatic garbage_ctrl();
    branch    = 1'($urandom);
    zero      = 1'($urandom);
    jump      = 1'($urandom);
    jal       = 1'($urandom);
    jr        = 1'($urandom);
    br_offset = 16'($urandom);
    j_target  = 8'($urandom);
    jr_addr   = 8'($urandom);
  endtask

  task automatic run_inst(int lat, int rdy, bit r, bit j, bit l, bit b, bit z,
                          logic [IW-1:0] o, logic [AW-1:0] t, logic [AW-1:0] a);
    int n;
    bit tk;
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) begin
      flag("req_timeout");
      return;
    end
    repeat (lat) begin
      @(posedge clk); #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = mem[imem_addr];
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    repeat (rdy) begin
      garbage_ctrl();
      @(posedge clk); #1;
    end
    jr = r; jump = j; jal = l; branch = b; zero = z;
    br_offset = o; j_target = t; jr_addr = a;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    garbage_ctrl();
    tk = r || j || l || (b && z);
    exp_cnt = exp_cnt + 16'd1;
    red_q.push_back(tk);
    cnt_q.push_back(exp_cnt);
    exp_pc = next_pc(exp_pc, r, j, l, b, z, o, t, a);
    issue(exp_pc);
  endtask

  task automatic check_reset();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_link", 32'(link_addr), 32'd1);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_count", 32'(inst_count), 32'd0);
  endtask

  // Monitor: compares DUT activity against the queued expectations.
  initial begin
    logic          prev_req;
    logic          prev_ack;
    logic          prev_valid;
    logic          prev_hs;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] prev_pc;
    logic [DW-1:0] prev_inst;
    logic [AW-1:0] ep;
    logic          hs;
    prev_req = 0; prev_ack = 0; prev_valid = 0; prev_hs = 0;
    prev_addr = '0; prev_pc = '0; prev_inst = '0;
    forever begin
      @(negedge clk);
      hs = 1'b0;
      if (rst_n) begin
        if (imem_req && !prev_req) begin
          if (addr_q.size() == 0) flag("addr_q_empty");
          else chk("imem_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
        end else if (imem_req && prev_req) begin
          chk("addr_stable", 32'(imem_addr), 32'(prev_addr));
        end
        if (prev_req && !imem_req && !prev_ack) flag("req_dropped_without_ack");
        if (inst_valid && prev_valid && !prev_hs) begin
          chk("inst_stable", inst, prev_inst);
          chk("pc_stable", 32'(pc_out), 32'(prev_pc));
        end
        if (prev_hs) begin
          if (red_q.size() == 0 || cnt_q.size() == 0) begin
            flag("redirect_q_empty");
          end else begin
            chk("redirect", 32'(redirect), 32'(red_q.pop_front()));
            chk("inst_count", 32'(inst_count), 32'(cnt_q.pop_front()));
          end
        end else begin
          chk("redirect_idle", 32'(redirect), 32'd0);
        end
        hs = inst_valid && inst_ready;
        if (hs) begin
          if (ipc_q.size() == 0) begin
            flag("inst_q_empty");
          end else begin
            ep = ipc_q.pop_front();
            chk("pc_out", 32'(pc_out), 32'(ep));
            chk("inst", inst, mem[ep]);
            chk("link_addr", 32'(link_addr), 32'((int'(ep) + 1) % M));
          end
        end
      end
      prev_req   = imem_req;
      prev_ack   = imem_ack;
      prev_valid = inst_valid;
      prev_hs    = hs;
      prev_addr  = imem_addr;
      prev_pc    = pc_out;
      prev_inst  = inst;
    end
  end

  initial begin
    #1_000_000;
    flag("watchdog_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int lat, rdy;
    bit r, j, l, b, z;
    logic [IW-1:0] o;
    for (int i = 0; i < M; i++) mem[i] = $urandom;
    exp_pc  = '0;
    exp_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    issue(exp_pc);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequential run 0,1,2 then jr to 0x10
    repeat (3) run_inst(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    run_inst(1, 0, 1, 0, 0, 0, 0, '0, '0, 8'h10);
    // Taken branch -3 from 0x10, then not-taken from 0x10
    run_inst(1, 0, 0, 0, 0, 1, 1, -16'sd3, '0, '0);
    run_inst(1, 0, 1, 0, 0, 0, 0, '0, '0, 8'h10);
    run_inst(1, 0, 0, 0, 0, 1, 0, -16'sd3, '0, '0);
    // Priority at 0x20
    run_inst(1, 0, 0, 1, 0, 0, 0, '0, 8'h20, '0);
    run_inst(2, 1, 1, 1, 0, 1, 1, 16'sd5, 8'h77, 8'h55);
    run_inst(1, 0, 1, 0, 0, 0, 0, '0, '0, 8'h20);
    run_inst(1, 0, 0, 1, 0, 1, 1, 16'sd5, 8'h77, 8'h55);
    run_inst(1, 0, 0, 0, 1, 0, 0, '0, 8'h20, '0);
    run_inst(1, 0, 0, 0, 1, 0, 0, '0, 8'hFF, '0);
    // Slow memory and backpressure at 0xFF, sequential wrap to 0
    run_inst(4, 5, 0, 0, 0, 0, 0, '0, '0, '0);
    run_inst(1, 0, 1, 0, 0, 0, 0, '0, '0, 8'hFE);
    run_inst(1, 0, 0, 0, 0, 1, 1, 16'sd2, '0, '0);

    for (int k = 0; k < 200; k++) begin
      lat = $urandom_range(1, 4);
      rdy = $urandom_range(0, 3);
      r = ($urandom_range(0, 7) == 0);
      j = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 2) == 0);
      z = 1'($urandom);
      if ($urandom_range(0, 1) == 1) o = 16'($urandom_range(0, 15)) - 16'd8;
      else o = 16'($urandom);
      run_inst(lat, rdy, r, j, l, b, z, o, 8'($urandom), 8'($urandom));
    end

    // Reset lands on the same edge as an ack
    while (!imem_req) begin
      @(posedge clk); #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    rst_n      = 1'b0;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    addr_q.delete();
    ipc_q.delete();
    red_q.delete();
    cnt_q.delete();
    exp_pc  = '0;
    exp_cnt = '0;
    @(negedge clk);
    check_reset();
    issue(exp_pc);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_wait_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    repeat (3) run_inst(1, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
